// File: rtl/bp_fetch_ctrl_pkg.sv
// Shared constants and types for the fetch-stage branch
// prediction tracker.
package bp_pkg;

    localparam logic [6:0] BR_OP   = 7'b110_0011;
    localparam logic [6:0] JAL_OP  = 7'b110_1111;
    localparam logic [6:0] JALR_OP = 7'b110_0111;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } pred_t;

    localparam pred_t PRED_NONE = '0;

endpackage

// File: rtl/bp_fetch_ctrl_if.sv
// Pipeline-side signal bundle of the fetch controller:
// hazard stalls, BTB result, D/E resolution inputs, PC and flushes.
interface bp_fetch_ctrl_if #(
    parameter int CNT_WIDTH = bp_pkg::CNT_W
);
    logic                 StallF;
    logic                 StallD;
    logic                 StallE;
    logic                 PredictedF;
    logic [31:0]          PredictedPC;
    logic                 JalD;
    logic [31:0]          JalNPC;
    logic                 JalrE;
    logic [31:0]          JalrNPC;
    logic [6:0]           OpE;
    logic [31:0]          PCE;
    logic                 BranchE;
    logic [31:0]          BrNPC;
    logic [31:0]          PCF;
    logic                 FlushD;
    logic                 FlushE;
    logic [CNT_WIDTH-1:0] BrCnt;
    logic [CNT_WIDTH-1:0] MissCnt;

    modport master (
        output StallF, StallD, StallE,
        output PredictedF, PredictedPC,
        output JalD, JalNPC, JalrE, JalrNPC,
        output OpE, PCE, BranchE, BrNPC,
        input  PCF, FlushD, FlushE, BrCnt, MissCnt
    );

    modport slave (
        input  StallF, StallD, StallE,
        input  PredictedF, PredictedPC,
        input  JalD, JalNPC, JalrE, JalrNPC,
        input  OpE, PCE, BranchE, BrNPC,
        output PCF, FlushD, FlushE, BrCnt, MissCnt
    );

endinterface

// File: rtl/bp_fetch_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module bp_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // count enabled events until saturated
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (en && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/bp_fetch_ctrl.sv
// Fetch next-PC selection, prediction tracking through D/E,
// EX misprediction detection with redirect/flush and perf counters.
module bp_fetch_ctrl
    import bp_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          CNT_WIDTH = CNT_W
) (
    input logic              clk,
    input logic              rst,
    bp_fetch_ctrl_if.slave   b
);

    logic [31:0] pcf_q;
    logic [31:0] pc_next;
    pred_t       pred_d;
    pred_t       pred_e;
    logic        ex_valid;
    logic        is_br;
    logic        mispredict;
    logic        ex_redirect;
    logic        jal_take;
    logic [31:0] correct_pc;
    logic [31:0] redirect_pc;
    logic [CNT_WIDTH-1:0] br_cnt;
    logic [CNT_WIDTH-1:0] miss_cnt;

    // EX resolution, redirect target and flush generation
    always_comb begin
        ex_valid   = !b.StallE;
        is_br      = (b.OpE == BR_OP);
        mispredict = 1'b0;
        if (ex_valid) begin
            if (is_br && (b.BranchE != pred_e.taken))
                mispredict = 1'b1;
            if (is_br && b.BranchE && pred_e.taken
                && (b.BrNPC != pred_e.target))
                mispredict = 1'b1;
            if (!is_br && !b.JalrE && pred_e.taken)
                mispredict = 1'b1;
        end
        correct_pc  = (is_br && b.BranchE) ? b.BrNPC
                                           : b.PCE + 32'd4;
        redirect_pc = b.JalrE ? b.JalrNPC : correct_pc;
        ex_redirect = ex_valid && (mispredict || b.JalrE);
        jal_take    = b.JalD && !b.StallD;
    end

    // next-PC priority: EX redirect beats stall, then JAL, BTB, +4
    always_comb begin
        pc_next = pcf_q;
        if (ex_redirect)
            pc_next = redirect_pc;
        else if (b.StallF)
            pc_next = pcf_q;
        else if (jal_take)
            pc_next = b.JalNPC;
        else if (b.PredictedF)
            pc_next = b.PredictedPC;
        else
            pc_next = pcf_q + 32'd4;
    end

    // fetch PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcf_q <= PC_RESET;
        else
            pcf_q <= pc_next;
    end

    // prediction travels F->D; a stalled F injects a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pred_d <= PRED_NONE;
        else if (ex_redirect || jal_take)
            pred_d <= PRED_NONE;
        else if (!b.StallD)
            pred_d <= b.StallF ? PRED_NONE
                               : pred_t'{b.PredictedF, b.PredictedPC};
    end

    // prediction travels D->E
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pred_e <= PRED_NONE;
        else if (ex_redirect)
            pred_e <= PRED_NONE;
        else if (!b.StallE)
            pred_e <= pred_d;
    end

    bp_sat_counter #(.W(CNT_WIDTH)) u_br_cnt (
        .clk (clk),
        .rst (rst),
        .en  (ex_valid && is_br),
        .cnt (br_cnt)
    );

    bp_sat_counter #(.W(CNT_WIDTH)) u_miss_cnt (
        .clk (clk),
        .rst (rst),
        .en  (mispredict),
        .cnt (miss_cnt)
    );

    assign b.PCF     = pcf_q;
    assign b.FlushE  = ex_redirect;
    assign b.FlushD  = ex_redirect || jal_take;
    assign b.BrCnt   = br_cnt;
    assign b.MissCnt = miss_cnt;

endmodule

// File: tb/tb_bp_fetch_ctrl.sv
// Directed scoreboard bench for bp_fetch_ctrl; narrow counters
// so saturation is reachable.
module tb_bp_fetch_ctrl;
    import bp_pkg::*;

    localparam int CW = 4;

    typedef struct {
        logic [31:0] pc;
        int          br;
        int          miss;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    sb_t  sb[$];

    bp_fetch_ctrl_if #(.CNT_WIDTH(CW)) bif ();

    bp_fetch_ctrl #(
        .PC_RESET  (32'h0000_0000),
        .CNT_WIDTH (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .b   (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bif.StallF      = 1'b0;
        bif.StallD      = 1'b0;
        bif.StallE      = 1'b0;
        bif.PredictedF  = 1'b0;
        bif.PredictedPC = '0;
        bif.JalD        = 1'b0;
        bif.JalNPC      = '0;
        bif.JalrE       = 1'b0;
        bif.JalrNPC     = '0;
        bif.OpE         = '0;
        bif.PCE         = '0;
        bif.BranchE     = 1'b0;
        bif.BrNPC       = '0;
    endtask

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // inputs already driven; check flushes, queue next-state, clock
    task automatic step(input logic fd, input logic fe,
                        input logic [31:0] pc,
                        input int br, input int miss);
        sb_t e;
        #1;
        check("flushd", 64'(bif.FlushD), 64'(fd));
        check("flushe", 64'(bif.FlushE), 64'(fe));
        e.pc   = pc;
        e.br   = br;
        e.miss = miss;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 64'(1), 64'(0));
        end else begin
            e = sb.pop_front();
            check("pcf", 64'(bif.PCF), 64'(e.pc));
            check("brcnt", 64'(bif.BrCnt), 64'(e.br));
            check("misscnt", 64'(bif.MissCnt), 64'(e.miss));
        end
        idle();
    endtask

    task automatic br_e(input logic [31:0] pce, input logic tkn,
                        input logic [31:0] tgt);
        bif.OpE     = BR_OP;
        bif.PCE     = pce;
        bif.BranchE = tkn;
        bif.BrNPC   = tgt;
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        check("rst_pcf", 64'(bif.PCF), 64'h0);
        check("rst_br", 64'(bif.BrCnt), 64'h0);
        check("rst_miss", 64'(bif.MissCnt), 64'h0);
        check("rst_fd", 64'(bif.FlushD), 64'h0);
        check("rst_fe", 64'(bif.FlushE), 64'h0);
        #5 rst = 1'b0;

        // sequential fetch up to 0x20
        for (int pc = 4; pc <= 32'h20; pc += 4)
            step(0, 0, 32'(pc), 0, 0);

        // correct taken prediction resolved in EX
        bif.PredictedF  = 1'b1;
        bif.PredictedPC = 32'h100;
        step(0, 0, 32'h100, 0, 0);
        step(0, 0, 32'h104, 0, 0);
        br_e(32'h20, 1'b1, 32'h100);
        step(0, 0, 32'h108, 1, 0);

        // predicted taken, actually not taken
        bif.PredictedF  = 1'b1;
        bif.PredictedPC = 32'h100;
        step(0, 0, 32'h100, 1, 0);
        step(0, 0, 32'h104, 1, 0);
        br_e(32'h20, 1'b0, 32'h100);
        step(1, 1, 32'h24, 2, 1);

        // unpredicted taken branch overrides StallF
        br_e(32'h40, 1'b1, 32'h80);
        bif.StallF = 1'b1;
        step(1, 1, 32'h80, 3, 2);

        // JALR in E beats JAL in D
        bif.JalD    = 1'b1;
        bif.JalNPC  = 32'h200;
        bif.JalrE   = 1'b1;
        bif.JalrNPC = 32'h300;
        step(1, 1, 32'h300, 3, 2);

        // JAL alone flushes D only
        bif.JalD   = 1'b1;
        bif.JalNPC = 32'h200;
        step(1, 0, 32'h200, 3, 2);

        // JAL with StallD is not taken
        bif.JalD   = 1'b1;
        bif.JalNPC = 32'h800;
        bif.StallD = 1'b1;
        step(0, 0, 32'h204, 3, 2);

        // StallF holds PCF
        bif.StallF = 1'b1;
        step(0, 0, 32'h204, 3, 2);

        // stale prediction on a non-branch, PCE+4 wraps
        bif.PredictedF  = 1'b1;
        bif.PredictedPC = 32'h400;
        step(0, 0, 32'h400, 3, 2);
        step(0, 0, 32'h404, 3, 2);
        bif.OpE = 7'h13;
        bif.PCE = 32'hFFFF_FFFC;
        step(1, 1, 32'h0, 3, 3);

        // mispredict held in E: nothing happens until release
        for (int i = 0; i < 3; i++) begin
            br_e(32'h30, 1'b1, 32'h500);
            bif.StallF = 1'b1;
            bif.StallD = 1'b1;
            bif.StallE = 1'b1;
            step(0, 0, 32'h0, 3, 3);
        end
        br_e(32'h30, 1'b1, 32'h500);
        step(1, 1, 32'h500, 4, 4);

        // drive both counters into saturation
        for (int i = 1; i <= 13; i++) begin
            br_e(32'h30, 1'b1, 32'h600);
            step(1, 1, 32'h600, sat(4 + i), sat(4 + i));
        end

        // held mispredict at saturation
        for (int i = 0; i < 3; i++) begin
            br_e(32'h30, 1'b1, 32'h500);
            bif.StallF = 1'b1;
            bif.StallD = 1'b1;
            bif.StallE = 1'b1;
            step(0, 0, 32'h600, 15, 15);
        end
        br_e(32'h30, 1'b1, 32'h500);
        step(1, 1, 32'h500, 15, 15);

        // reset mid-operation
        rst = 1'b1;
        #1;
        check("mid_pcf", 64'(bif.PCF), 64'h0);
        check("mid_br", 64'(bif.BrCnt), 64'h0);
        check("mid_miss", 64'(bif.MissCnt), 64'h0);
        rst = 1'b0;
        step(0, 0, 32'h4, 0, 0);
        bif.PredictedF  = 1'b1;
        bif.PredictedPC = 32'h700;
        step(0, 0, 32'h700, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
